// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Two-master Avalon-MM arbiter in front of the single slave port (s_*) of an
// SDRAM controller. It shares that port between two bursting requesters, for
// example a video fetch engine and a CPU/DMA path.
//
// A master keeps its grant for a whole burst. For a write, the grant lasts
// until the controller has accepted every write beat. For a read, it lasts
// until every read beat has been returned. When both masters request in the
// same cycle, a round-robin pointer picks the winner.
//
// Optional feature (compile-time macro SDRAM_ARB_FIXED_PRIO_EN):
//   - Defined: master 0 always wins simultaneous requests. The round-robin
//     pointer is held at 0.
//   - Undefined (default): round-robin between the two masters.
//   Burst locking is identical in both modes.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   m0_* / m1_*           master-side Avalon-MM slave ports:
//                           read, write, address, writedata, burstcount and
//                           byteenable in; waitrequest, readdatavalid and
//                           readdata out
//   s_*                   controller-side Avalon-MM master port:
//                           read, write, address, writedata, burstcount and
//                           byteenable out; waitrequest, readdatavalid and
//                           readdata in
//   grant                 one-hot current owner (01 = m0, 10 = m1, 00 = idle)
//   err_burst             sticky flag: a request with an illegal burstcount
//                         was seen (cleared only by reset)
//   fsm_state             arbiter state (0 = IDLE, 1 = FWD, 2 = RD_WAIT)
//
// Handshake (all ports): a command or write beat transfers on a cycle where
// read/write is high and waitrequest is low. A read beat transfers on a cycle
// where readdatavalid is high. There is no other qualification.
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int AW  = 22,
  parameter int DW  = 16,
  parameter int BCW = 9
) (
  input  logic           clk,
  input  logic           reset,

  input  logic           m0_read,
  input  logic           m0_write,
  input  logic [AW-1:0]  m0_address,
  input  logic [DW-1:0]  m0_writedata,
  input  logic [BCW-1:0] m0_burstcount,
  input  logic [1:0]     m0_byteenable,
  output logic           m0_waitrequest,
  output logic           m0_readdatavalid,
  output logic [DW-1:0]  m0_readdata,

  input  logic           m1_read,
  input  logic           m1_write,
  input  logic [AW-1:0]  m1_address,
  input  logic [DW-1:0]  m1_writedata,
  input  logic [BCW-1:0] m1_burstcount,
  input  logic [1:0]     m1_byteenable,
  output logic           m1_waitrequest,
  output logic           m1_readdatavalid,
  output logic [DW-1:0]  m1_readdata,

  output logic           s_read,
  output logic           s_write,
  output logic [AW-1:0]  s_address,
  output logic [DW-1:0]  s_writedata,
  output logic [BCW-1:0] s_burstcount,
  output logic [1:0]     s_byteenable,
  input  logic           s_waitrequest,
  input  logic           s_readdatavalid,
  input  logic [DW-1:0]  s_readdata,

  output logic [1:0]     grant,
  output logic           err_burst,
  output logic [1:0]     fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t         state;
  logic [BCW-1:0] bc;       // burst length latched at grant time
  logic [BCW-1:0] cnt;      // beats completed so far in the current burst
  logic           op_read;  // latched operation: 1 = read burst, 0 = write
  logic           rr;       // master preferred on a tie (0 = m0, 1 = m1)

  // Only these burst lengths are legal: 1, 2, 4, 8 and 256.
  // 256 is only representable when the counter is at least 9 bits wide.
  function automatic logic legal_bc(input logic [BCW-1:0] b);
    return (b == BCW'(1)) || (b == BCW'(2)) || (b == BCW'(4)) ||
           (b == BCW'(8)) || ((BCW > 8) && (b == BCW'(256)));
  endfunction

  logic m0_cmd, m1_cmd;
  logic req0, req1;
  logic bad0, bad1;
  logic pick1;
  logic in_fwd, in_rdw;
  logic wr_beat, rd_accept, rd_beat;
  logic [BCW-1:0] cnt_nxt;
  logic last_beat;

  assign m0_cmd = m0_read | m0_write;
  assign m1_cmd = m1_read | m1_write;

  assign req0 = m0_cmd && legal_bc(m0_burstcount);
  assign req1 = m1_cmd && legal_bc(m1_burstcount);

  // An owner's burstcount was already checked when it was granted. Only
  // requests that are not currently being served can raise the error flag.
  assign bad0 = m0_cmd && !legal_bc(m0_burstcount) && !grant[0];
  assign bad1 = m1_cmd && !legal_bc(m1_burstcount) && !grant[1];

  // Tie-break. In fixed-priority mode rr never leaves 0, so m0 always wins.
  assign pick1 = rr;

  assign in_fwd = (state == FWD);
  assign in_rdw = (state == RD_WAIT);

  // Forward the owner's command only while in FWD. The latched op decides
  // which strobe passes, so if a master raises both, only the read is seen.
  always_comb begin
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_address      = grant[1] ? m1_address    : m0_address;
    s_writedata    = grant[1] ? m1_writedata  : m0_writedata;
    s_burstcount   = grant[1] ? m1_burstcount : m0_burstcount;
    s_byteenable   = grant[1] ? m1_byteenable : m0_byteenable;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (in_fwd) begin
      if (op_read) s_read  = grant[1] ? m1_read  : m0_read;
      else         s_write = grant[1] ? m1_write : m0_write;
      if (grant[0]) m0_waitrequest = s_waitrequest;
      if (grant[1]) m1_waitrequest = s_waitrequest;
    end
  end

  // Read data fans out to both masters. Only the owner sees readdatavalid,
  // and only while the arbiter is collecting that owner's read beats.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = in_rdw && grant[0] && s_readdatavalid;
  assign m1_readdatavalid = in_rdw && grant[1] && s_readdatavalid;

  assign wr_beat   = in_fwd && s_write && !s_waitrequest;
  assign rd_accept = in_fwd && s_read  && !s_waitrequest;
  assign rd_beat   = in_rdw && s_readdatavalid;

  // The count is BCW bits wide, so count+1 reaches 256 when BCW = 9.
  assign cnt_nxt   = cnt + 1'b1;
  assign last_beat = (cnt_nxt == bc);

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rr        <= 1'b0;
      cnt       <= '0;
      bc        <= '0;
      op_read   <= 1'b0;
      err_burst <= 1'b0;
    end else begin
      if (bad0 || bad1) err_burst <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || !pick1)) begin
            state   <= FWD;
            grant   <= 2'b01;
            bc      <= m0_burstcount;
            op_read <= m0_read;
          end else if (req1) begin
            state   <= FWD;
            grant   <= 2'b10;
            bc      <= m1_burstcount;
            op_read <= m1_read;
          end
        end

        FWD: begin
          if (wr_beat) begin
            if (last_beat) begin
              state <= IDLE;
              grant <= 2'b00;
              cnt   <= '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
              rr    <= 1'b0;
`else
              // Next tie goes to the master that was not just served.
              rr    <= grant[0];
`endif
            end else begin
              cnt <= cnt_nxt;
            end
          end else if (rd_accept) begin
            // One read command covers the whole burst. Stop driving s_read
            // and wait for the data beats.
            state <= RD_WAIT;
            cnt   <= '0;
          end
        end

        RD_WAIT: begin
          if (rd_beat) begin
            if (last_beat) begin
              state <= IDLE;
              grant <= 2'b00;
              cnt   <= '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
              rr    <= 1'b0;
`else
              rr    <= grant[0];
`endif
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed bench for sdram_arbiter. The bench itself plays the SDRAM
// controller: it drives s_waitrequest, s_readdatavalid and s_readdata.
//
// Inputs change on the falling clock edge. Outputs are sampled 1 ns later,
// well away from the rising edge. Expected read data goes into exp_q. Data
// that the owning master actually receives is captured in obs_q, and the two
// queues are compared.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int BCW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0]  m0_address, m1_address;
  logic [DW-1:0]  m0_writedata, m1_writedata;
  logic [BCW-1:0] m0_burstcount, m1_burstcount;
  logic [1:0]     m0_byteenable, m1_byteenable;
  logic           m0_waitrequest, m1_waitrequest;
  logic           m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0]  m0_readdata, m1_readdata;
  logic           s_read, s_write;
  logic [AW-1:0]  s_address;
  logic [DW-1:0]  s_writedata;
  logic [BCW-1:0] s_burstcount;
  logic [1:0]     s_byteenable;
  logic           s_waitrequest, s_readdatavalid;
  logic [DW-1:0]  s_readdata;
  logic [1:0]     grant;
  logic           err_burst;
  logic [1:0]     fsm_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];

  sdram_arbiter #(.AW(AW), .DW(DW), .BCW(BCW)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount),
    .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_burstcount(s_burstcount),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .grant(grant), .err_burst(err_burst), .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------- drivers
  task automatic clear_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0;
    m0_burstcount = 9'd1; m0_byteenable = 2'b11;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0;
    m1_burstcount = 9'd1; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Acts as the controller for one read burst owned by exp_g.
  // Sequence:
  //   1. Wait (bounded) for the grant.
  //   2. Hold waitrequest high for 'stall' cycles, then accept the command.
  //   3. Return n beats, leaving a gap every fourth cycle.
  // Reports:
  //   held  - cycles where s_read was high and stalled
  //   beats - beats returned
  //   bad   - cycles with any protocol anomaly
  task automatic drive_read(input logic [1:0] exp_g, input int n, input int stall,
                            input logic [DW-1:0] base, input logic [AW-1:0] addr,
                            output int held, output int beats, output int bad);
    int   cyc;
    logic v, own_w, oth_w, own_v, oth_v;
    held = 0; beats = 0; bad = 0; cyc = 0;
    @(negedge clk);
    s_waitrequest = (stall > 0);
    #1;
    while (grant !== exp_g && cyc < 4) begin
      @(negedge clk); #1; cyc++;
    end
    if (grant !== exp_g) bad++;
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) begin
        @(negedge clk);
        s_waitrequest = (k < stall);
        #1;
      end
      own_w = exp_g[0] ? m0_waitrequest : m1_waitrequest;
      oth_w = exp_g[0] ? m1_waitrequest : m0_waitrequest;
      if (grant !== exp_g || s_read !== 1'b1 || s_write !== 1'b0 ||
          s_address !== addr || own_w !== s_waitrequest || oth_w !== 1'b1) bad++;
      if (s_read === 1'b1 && s_waitrequest) held++;
    end
    s_waitrequest = 1'b0;
    cyc = 0;
    while (beats < n && cyc < 2 * n + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (exp_g[0]) m0_read = 1'b0; else m1_read = 1'b0;
      end
      v = ((cyc % 4) != 0);
      s_readdatavalid = v;
      s_readdata = base + DW'(beats);
      #1;
      own_v = exp_g[0] ? m0_readdatavalid : m1_readdatavalid;
      oth_v = exp_g[0] ? m1_readdatavalid : m0_readdatavalid;
      if (grant !== exp_g || s_read !== 1'b0 || s_write !== 1'b0 || own_v !== v ||
          oth_v !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) bad++;
      if (own_v === 1'b1) obs_q.push_back(exp_g[0] ? m0_readdata : m1_readdata);
      if (v) beats++;
    end
  endtask

  // Drains the scoreboard and returns the number of mismatching entries.
  function automatic int sb_drain();
    int mism = 0;
    logic [DW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) mism++;
      else if (obs_q.pop_front() !== e) mism++;
    end
    mism += obs_q.size();
    obs_q.delete();
    return mism;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m0_read = 1'b1;                  // a request during reset must be ignored
    repeat (3) @(negedge clk);
    #1;
    chk_cnt++;
    if ({grant, err_burst, s_read, s_write, m0_waitrequest, m1_waitrequest,
         m0_readdatavalid, m1_readdatavalid, fsm_state} !== 11'b00_0_0_0_1_1_0_0_00)
      $display("FAIL reset_values: got grant=%b err=%b rd=%b wr=%b w0=%b w1=%b v0=%b v1=%b st=%0d, expected 00 0 0 0 1 1 0 0 0",
               grant, err_burst, s_read, s_write, m0_waitrequest, m1_waitrequest,
               m0_readdatavalid, m1_readdatavalid, fsm_state);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    m0_read = 1'b0;
  endtask

  task automatic test_write_burst();
    int beats, cycles, bad;
    logic stall;
    logic [DW-1:0] e;
    @(negedge clk);
    m0_write = 1'b1; m0_burstcount = 9'd4; m0_address = 22'h000100;
    m0_writedata = 16'h1111; s_waitrequest = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, s_write, m0_waitrequest} !== 4'b00_0_1)
      $display("FAIL wr_latency: got grant=%b s_write=%b w0=%b, expected 00 0 1",
               grant, s_write, m0_waitrequest);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(16'h1111 * i));
    beats = 0; cycles = 0; bad = 0;
    while (beats < 4 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      stall = (cycles == 2);
      s_waitrequest = stall;
      m0_writedata = DW'(16'h1111 * (beats + 1));
      #1;
      if ({grant, s_write, s_address, s_burstcount, m0_waitrequest, m1_waitrequest} !==
          {2'b01, 1'b1, 22'h000100, 9'd4, stall, 1'b1}) bad++;
      if (!stall) begin
        e = exp_q.pop_front();
        if (s_writedata !== e) bad++;
        beats++;
      end
    end
    chk_cnt++;
    if (beats != 4) $display("FAIL wr_beat_count: got %0d beats, expected 4", beats);
    else pass_cnt++;
    chk_cnt++;
    if (bad != 0) $display("FAIL wr_forwarding: got %0d bad cycles, expected 0", bad);
    else pass_cnt++;
    @(negedge clk);
    m0_write = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, s_write, m0_waitrequest, m1_waitrequest} !== 5'b00_0_1_1)
      $display("FAIL wr_release: got grant=%b s_write=%b w0=%b w1=%b, expected 00 0 1 1",
               grant, s_write, m0_waitrequest, m1_waitrequest);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_dual_read();
    int held, beats, bad, mism;
    do_reset();
    @(negedge clk);
    m0_read = 1'b1; m0_burstcount = 9'd8; m0_address = 22'h002000;
    m1_read = 1'b1; m1_burstcount = 9'd8; m1_address = 22'h003000;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'hA000 + DW'(i));
    drive_read(2'b01, 8, 2, 16'hA000, 22'h002000, held, beats, bad);
    mism = sb_drain();
    chk_cnt++;
    if (held != 2 || beats != 8 || bad != 0 || mism != 0)
      $display("FAIL dual_m0_burst: got held=%0d beats=%0d bad=%0d mism=%0d, expected 2 8 0 0",
               held, beats, bad, mism);
    else pass_cnt++;
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, m1_waitrequest, m0_readdatavalid} !== 4'b00_1_0)
      $display("FAIL dual_gap: got grant=%b w1=%b v0=%b, expected 00 1 0",
               grant, m1_waitrequest, m0_readdatavalid);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'hB000 + DW'(i));
    drive_read(2'b10, 8, 0, 16'hB000, 22'h003000, held, beats, bad);
    mism = sb_drain();
    chk_cnt++;
    if (held != 0 || beats != 8 || bad != 0 || mism != 0)
      $display("FAIL dual_m1_burst: got held=%0d beats=%0d bad=%0d mism=%0d, expected 0 8 0 0",
               held, beats, bad, mism);
    else pass_cnt++;
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk_cnt++;
    if (grant !== 2'b00) $display("FAIL dual_end: got grant=%b, expected 00", grant);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    logic [1:0] exp_g;
    logic [DW-1:0] exp_d;
    do_reset();
    @(negedge clk);
    m0_write = 1'b1; m0_burstcount = 9'd1; m0_writedata = 16'h0A0A;
    m1_write = 1'b1; m1_burstcount = 9'd1; m1_writedata = 16'h0B0B;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      #1;
      if (grant !== 2'b00) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
        exp_d = exp_g[0] ? 16'h0A0A : 16'h0B0B;
        chk_cnt++;
        if (grant !== exp_g || s_write !== 1'b1 || s_writedata !== exp_d)
          $display("FAIL b2b_round%0d: got grant=%b s_write=%b data=%h, expected %b 1 %h",
                   n, grant, s_write, s_writedata, exp_g, exp_d);
        else pass_cnt++;
        n++;
      end
    end
    chk_cnt++;
    if (n != 6) $display("FAIL b2b_grant_count: got %0d grants, expected 6", n);
    else pass_cnt++;
    @(negedge clk);
    m0_write = 1'b0; m1_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst_256();
    int held, beats, bad, mism;
    @(negedge clk);
    m1_read = 1'b1; m1_burstcount = 9'd256; m1_address = 22'h3FFF00;
    for (int i = 0; i < 256; i++) exp_q.push_back(16'h5000 + DW'(i));
    drive_read(2'b10, 256, 20, 16'h5000, 22'h3FFF00, held, beats, bad);
    mism = sb_drain();
    chk_cnt++;
    if (held != 20) $display("FAIL b256_held: got %0d stalled cycles, expected 20", held);
    else pass_cnt++;
    chk_cnt++;
    if (beats != 256 || bad != 0 || mism != 0)
      $display("FAIL b256_burst: got beats=%0d bad=%0d mism=%0d, expected 256 0 0",
               beats, bad, mism);
    else pass_cnt++;
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk_cnt++;
    if ({grant, m1_waitrequest, m1_readdatavalid} !== 4'b00_1_0)
      $display("FAIL b256_end: got grant=%b w1=%b v1=%b, expected 00 1 0",
               grant, m1_waitrequest, m1_readdatavalid);
    else pass_cnt++;
  endtask

  task automatic test_illegal_bc();
    int bad;
    @(negedge clk);
    m0_write = 1'b1; m0_burstcount = 9'd3;
    m1_write = 1'b1; m1_burstcount = 9'd1; m1_writedata = 16'hC3C3; m1_address = 22'h000055;
    s_waitrequest = 1'b0;
    #1;
    chk_cnt++;
    if ({err_burst, grant} !== 3'b0_00)
      $display("FAIL ill_before: got err=%b grant=%b, expected 0 00", err_burst, grant);
    else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({err_burst, grant, m0_waitrequest, s_write, s_writedata, s_burstcount} !==
        {1'b1, 2'b10, 1'b1, 1'b1, 16'hC3C3, 9'd1})
      $display("FAIL ill_m1_fwd: got err=%b grant=%b w0=%b s_write=%b data=%h bc=%0d, expected 1 10 1 1 c3c3 1",
               err_burst, grant, m0_waitrequest, s_write, s_writedata, s_burstcount);
    else pass_cnt++;
    @(negedge clk);
    m1_write = 1'b0;
    bad = 0;
    repeat (5) begin
      #1;
      if (grant !== 2'b00 || m0_waitrequest !== 1'b1 || s_write !== 1'b0) bad++;
      @(negedge clk);
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL ill_never_granted: got %0d bad cycles, expected 0", bad);
    else pass_cnt++;
    m0_write = 1'b0; m0_burstcount = 9'd1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++;
    if (err_burst !== 1'b1) $display("FAIL ill_sticky: got err=%b, expected 1", err_burst);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    m0_read = 1'b1; m0_burstcount = 9'd8; m0_address = 22'h000777; s_waitrequest = 1'b0;
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({grant, s_read} !== 3'b01_1)
      $display("FAIL rst_mid_cmd: got grant=%b s_read=%b, expected 01 1", grant, s_read);
    else pass_cnt++;
    @(negedge clk);
    m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'hD001;
    #1;
    chk_cnt++;
    if ({m0_readdatavalid, m0_readdata} !== {1'b1, 16'hD001})
      $display("FAIL rst_mid_beat1: got v0=%b data=%h, expected 1 d001", m0_readdatavalid, m0_readdata);
    else pass_cnt++;
    @(negedge clk);
    s_readdata = 16'hD002;
    m1_read = 1'b1; m1_burstcount = 9'd2; m1_address = 22'h000123;
    #1;
    chk_cnt++;
    if ({m0_readdatavalid, m1_readdatavalid, grant} !== 4'b1_0_01)
      $display("FAIL rst_mid_beat2: got v0=%b v1=%b grant=%b, expected 1 0 01",
               m0_readdatavalid, m1_readdatavalid, grant);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({grant, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
         s_read, s_write, err_burst} !== 9'b00_1_1_0_0_0_0_0)
      $display("FAIL rst_mid_abort: got grant=%b w0=%b w1=%b v0=%b v1=%b rd=%b wr=%b err=%b, expected 00 1 1 0 0 0 0 0",
               grant, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
               s_read, s_write, err_burst);
    else pass_cnt++;
    reset = 1'b0;
    s_readdatavalid = 1'b0;
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({grant, s_read, s_address} !== {2'b10, 1'b1, 22'h000123})
      $display("FAIL rst_mid_recover: got grant=%b s_read=%b addr=%h, expected 10 1 000123",
               grant, s_read, s_address);
    else pass_cnt++;
    do_reset();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_write_burst();
    test_dual_read();
    test_back_to_back();
    test_burst_256();
    test_illegal_bc();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the single SDRAM controller slave port; shares it between two bursting requesters (e.g. video fetch and CPU/DMA).
- Grants one master at a time, forwards its command/write beats, and routes read data back to the owner.
- Holds the grant for a whole burst: all write beats accepted, or all read beats returned.
- Round-robin between masters; sits between the masters and the controller's s_* port.

Parameters:
AW, 22, address width (matches controller s_address)
DW, 16, data width
BCW, 9, burstcount width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_read, m0_write  in  1  master 0 command
m0_address  in  AW  master 0 word address
m0_writedata  in  DW  master 0 write beat
m0_burstcount  in  BCW  master 0 burst length
m0_byteenable  in  2  master 0 byte enables
m0_waitrequest  out  1  master 0 stall
m0_readdatavalid  out  1  master 0 read beat valid
m0_readdata  out  DW  master 0 read data
m1_*  same set as m0_*, for master 1
s_read, s_write, s_address, s_writedata, s_burstcount, s_byteenable  out  (widths as above)  to controller
s_waitrequest, s_readdatavalid  in  1  from controller
s_readdata  in  DW  from controller
grant  out  2  one-hot current owner (debug)
err_burst  out  1  sticky: illegal burstcount seen

Behaviour:
- Clock/reset: one clock clk; reset synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - state=IDLE, grant=00, rr pointer=master 0, beat counter=0, err_burst=0.
  - s_read=s_write=0; m*_waitrequest=1; m*_readdatavalid=0.
- Reset mid-burst aborts immediately; the controller is not notified. The system resets both blocks together.
- Legal burstcounts: 1, 2, 4, 8, 256.
- IDLE:
  - Requester = m*_read|m*_write with a legal burstcount.
  - Only one requester: grant it. Both: grant the rr pointer's master.
  - Register grant, owner burstcount (bc) and op (read wins if both read and write asserted). Next cycle → FWD.
  - Arbitration latency: request seen in cycle N, forwarded to s_* in cycle N+1.
- Illegal burstcount request: never granted; that master's waitrequest stays 1; err_burst set (sticky until reset). The other master is still arbitrated normally.
- FWD:
  - s_* = owner's m* signals combinationally; owner waitrequest = s_waitrequest; non-owner waitrequest=1.
  - Write: a beat is accepted when s_write && !s_waitrequest; count beats. On beat bc → IDLE.
  - Read: command accepted when s_read && !s_waitrequest → RD_WAIT. s_read is forced 0 after acceptance.
- RD_WAIT:
  - s_read=s_write=0.
  - Owner m_readdatavalid = s_readdatavalid; count beats. On beat bc → IDLE.
  - Non-owner readdatavalid=0 always. readdata fans out to both masters, qualified by readdatavalid.
- Return to IDLE: rr pointer = the master not just served; grant=00.
- Owner drops request before acceptance: forwarding continues; no timeout. An Avalon violation by the master.
- Counter wraps at 2^BCW; bc=256 requires a 9-bit counter compare of count+1 == bc.
- No pipelined commands: a second command is not forwarded while the owner's read data is outstanding.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins simultaneous requests; rr pointer is unused and held at 0.
- Undefined: round-robin as above.
- Burst locking is identical in both modes.

Test Plan:
- m0 write, burstcount=4, data 0x1111..0x4444, m1 idle → s_write beats forwarded in order; grant=01 for 4 accepted beats, then 00; m1_waitrequest=1 throughout.
- m0 and m1 both read, burstcount=8, same cycle after reset → m0 served first: 8 m0_readdatavalid pulses, zero on m1. Then m1 served, 8 beats. m0_readdatavalid never seen during m1's burst.
- Back-to-back simultaneous requests, 3 rounds → grants alternate 01,10,01,10,...; with SDRAM_ARB_FIXED_PRIO_EN defined → all 01 while m0 keeps requesting.
- m1 read, burstcount=256 with s_waitrequest held high 20 cycles → s_read held 20 cycles; after acceptance, exactly 256 beats to m1; grant held until beat 256.
- m0 request, burstcount=3 → never granted; err_burst=1 next cycle; concurrent m1 write bc=1 completes normally.
- reset asserted mid read burst (after beat 2 of 8) → next cycle grant=00, all waitrequest=1, readdatavalid=0, s_read=s_write=0.
